// File: rtl/logicnet_input_quantizer.sv
// logicnet_input_quantizer
// ------------------------------------------------------------------------
// Front-end stage for the layer-0 neuron LUTs. Raw signed samples arrive
// one per handshake. Each sample is quantized to a 2-bit code against three
// programmable thresholds for its feature. The codes are packed into one flat
// vector, and that vector is handed downstream with a valid/ready handshake.
//
// Optional feature (macro LOGICNET_QUANT_STATS_EN): when the macro is defined,
// the block adds saturating frame and error counters and a stat_clr input.
// When the macro is undefined, those ports and their logic are absent.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   thr_wr_en  threshold write strobe
//   thr_addr   feature index of the write (ignored if >= NUM_FEATURES)
//   thr_sel    threshold slot 0..2 (3 is ignored)
//   thr_data   signed threshold value
//   s_valid    sample valid
//   s_ready    sample accept
//   s_data     signed raw sample
//   s_last     final sample of a vector
//   m_valid    vector valid
//   m_ready    downstream accept
//   m_data     packed codes, feature i at [2i+1:2i]
//   frame_err  one-cycle pulse on a framing error
//   stat_clr, stat_frames, stat_errs  (LOGICNET_QUANT_STATS_EN only)
//
// State  | meaning
// COLLECT| accepting and quantizing samples into the vector
// DRAIN  | long frame seen; discarding samples up to the next s_last
// HOLD   | vector presented on m_data, waiting for m_ready
module logicnet_input_quantizer #(
  parameter int NUM_FEATURES = 32,
  parameter int IN_WIDTH     = 16,
  parameter int IDX_W        = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      thr_wr_en,
  input  logic [IDX_W-1:0]          thr_addr,
  input  logic [1:0]                thr_sel,
  input  logic [IN_WIDTH-1:0]       thr_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [IN_WIDTH-1:0]       s_data,
  input  logic                      s_last,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [2*NUM_FEATURES-1:0] m_data,
  output logic                      frame_err
`ifdef LOGICNET_QUANT_STATS_EN
  ,
  input  logic                      stat_clr,
  output logic [15:0]               stat_frames,
  output logic [15:0]               stat_errs
`endif
);

  localparam int FW = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
  localparam logic [FW-1:0] LAST_IDX = FW'(NUM_FEATURES - 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t                    state_q;
  logic [FW-1:0]             idx_q;
  logic                      s_ready_q;
  logic                      m_valid_q;
  logic [2*NUM_FEATURES-1:0] m_data_q;
  logic                      frame_err_q;
  logic [IN_WIDTH-1:0]       thr_q [NUM_FEATURES][3];

  logic                      addr_ok;
  logic                      thr_wr_hit;
  logic [FW-1:0]             thr_idx;
  logic                      accept;
  logic [2:0]                ge;
  logic [1:0]                code_d;

  // The range check uses the full address. The truncated index is used only
  // after the check passes, so an out-of-range address can never alias onto
  // a real feature.
  assign addr_ok    = (32'(thr_addr) < 32'(NUM_FEATURES));
  assign thr_wr_hit = thr_wr_en && addr_ok && (thr_sel != 2'd3);
  assign thr_idx    = thr_addr[FW-1:0];
  assign accept     = s_valid && s_ready_q;

  // Each slot met adds one, so unordered thresholds still give a 0..3 code.
  always_comb begin
    ge     = 3'b000;
    code_d = 2'd0;
    for (int k = 0; k < 3; k++) begin
      ge[k] = ($signed(s_data) >= $signed(thr_q[idx_q][k]));
    end
    code_d = {1'b0, ge[0]} + {1'b0, ge[1]} + {1'b0, ge[2]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int f = 0; f < NUM_FEATURES; f++) begin
        for (int k = 0; k < 3; k++) begin
          thr_q[f][k] <= '0;
        end
      end
    end else if (thr_wr_hit) begin
      thr_q[thr_idx][thr_sel] <= thr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= COLLECT;
      idx_q       <= '0;
      s_ready_q   <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        COLLECT: begin
          s_ready_q <= 1'b1;
          if (accept) begin
            m_data_q[{idx_q, 1'b0} +: 2] <= code_d;
            if (idx_q == LAST_IDX) begin
              idx_q <= '0;
              if (s_last) begin
                state_q   <= HOLD;
                m_valid_q <= 1'b1;
                s_ready_q <= 1'b0;
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= DRAIN;
              end
            end else if (s_last) begin
              // A short frame drops its partial vector. The stale codes in
              // m_data_q are overwritten by the next frame.
              frame_err_q <= 1'b1;
              idx_q       <= '0;
            end else begin
              idx_q <= idx_q + FW'(1);
            end
          end
        end
        DRAIN: begin
          s_ready_q <= 1'b1;
          if (accept && s_last) begin
            state_q <= COLLECT;
          end
        end
        HOLD: begin
          s_ready_q <= 1'b0;
          if (m_valid_q && m_ready) begin
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b1;
            state_q   <= COLLECT;
          end
        end
        default: begin
          state_q   <= COLLECT;
          s_ready_q <= 1'b0;
          m_valid_q <= 1'b0;
          idx_q     <= '0;
        end
      endcase
    end
  end

  assign s_ready   = s_ready_q;
  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign frame_err = frame_err_q;

`ifdef LOGICNET_QUANT_STATS_EN
  logic [15:0] stat_frames_q;
  logic [15:0] stat_errs_q;

  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat_frames_q <= '0;
      stat_errs_q   <= '0;
    end else begin
      if (m_valid_q && m_ready && (stat_frames_q != 16'hFFFF)) begin
        stat_frames_q <= stat_frames_q + 16'd1;
      end
      if (frame_err_q && (stat_errs_q != 16'hFFFF)) begin
        stat_errs_q <= stat_errs_q + 16'd1;
      end
    end
  end

  assign stat_frames = stat_frames_q;
  assign stat_errs   = stat_errs_q;
`endif

endmodule

// File: tb/tb_logicnet_input_quantizer.sv
// Directed bench for logicnet_input_quantizer (NUM_FEATURES=32, IN_WIDTH=16).
// Inputs are driven and outputs are sampled on the falling edge.
module tb_logicnet_input_quantizer;

  localparam logic [15:0] NEG5   = 16'hFFFB;
  localparam logic [15:0] POS5   = 16'h0005;
  localparam logic [15:0] NEG1   = 16'hFFFF;
  localparam logic [63:0] PAT_CC = 64'hCCCC_CCCC_CCCC_CCCC;
  localparam logic [63:0] PAT_33 = 64'h3333_3333_3333_3333;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        thr_wr_en = 1'b0;
  logic [7:0]  thr_addr = '0;
  logic [1:0]  thr_sel = '0;
  logic [15:0] thr_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [63:0] m_data;
  logic        frame_err;
`ifdef LOGICNET_QUANT_STATS_EN
  logic        stat_clr = 1'b0;
  logic [15:0] stat_frames;
  logic [15:0] stat_errs;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logicnet_input_quantizer #(.NUM_FEATURES(32), .IN_WIDTH(16), .IDX_W(8)) dut (
    .clk(clk), .rst(rst),
    .thr_wr_en(thr_wr_en), .thr_addr(thr_addr), .thr_sel(thr_sel), .thr_data(thr_data),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .frame_err(frame_err)
`ifdef LOGICNET_QUANT_STATS_EN
    , .stat_clr(stat_clr), .stat_frames(stat_frames), .stat_errs(stat_errs)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [15:0] d, input logic last);
    int w;
    w = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (!s_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!s_ready) begin
      tests++; fails++;
      $display("FAIL send_timeout s_ready=%b required=1", s_ready);
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [15:0] ve, input logic [15:0] vo,
                            output int errs, output int err_at, output logic mv);
    errs = 0; err_at = 0; mv = 1'b0;
    for (int i = 0; i < n; i++) begin
      send(((i % 2) != 0) ? vo : ve, (i == n - 1));
      if (frame_err) begin
        errs++;
        if (errs == 1) err_at = i + 1;
      end
      if (m_valid) mv = 1'b1;
    end
  endtask

  task automatic wr_thr(input logic [7:0] a, input logic [1:0] sel, input logic [15:0] d);
    thr_wr_en = 1'b1; thr_addr = a; thr_sel = sel; thr_data = d;
    @(negedge clk);
    thr_wr_en = 1'b0;
  endtask

  task automatic handoff();
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (s_ready !== 1'b0) begin fails++; $display("FAIL rst_s_ready got=%b exp=0", s_ready); end
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL rst_m_valid got=%b exp=0", m_valid); end
    tests++; if (m_data !== 64'h0) begin fails++; $display("FAIL rst_m_data got=%h exp=0", m_data); end
    tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL rst_frame_err got=%b exp=0", frame_err); end
    rst = 1'b0;
    @(negedge clk);
    tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL rst_ready_rise got=%b exp=1", s_ready); end
  endtask

  task automatic test_backpressure();
    int errs, err_at;
    logic mv;
    send_frame(32, NEG5, POS5, errs, err_at, mv);
    tests++; if (mv !== 1'b1) begin fails++; $display("FAIL bp_mvalid got=%b exp=1", mv); end
    tests++; if (errs != 0) begin fails++; $display("FAIL bp_errs got=%0d exp=0", errs); end
    // A sample is offered during HOLD; it must not be taken.
    s_valid = 1'b1; s_data = 16'h7FFF; s_last = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tests++; if (m_valid !== 1'b1) begin fails++; $display("FAIL bp_hold_valid cyc%0d got=%b exp=1", c, m_valid); end
      tests++; if (m_data !== PAT_CC) begin fails++; $display("FAIL bp_hold_data cyc%0d got=%h exp=%h", c, m_data, PAT_CC); end
      tests++; if (s_ready !== 1'b0) begin fails++; $display("FAIL bp_hold_ready cyc%0d got=%b exp=0", c, s_ready); end
      @(negedge clk);
    end
    s_valid = 1'b0; s_last = 1'b0;
    handoff();
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL bp_release_valid got=%b exp=0", m_valid); end
    tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready got=%b exp=1", s_ready); end
    tests++; if (m_data !== PAT_CC) begin fails++; $display("FAIL bp_keep_data got=%h exp=%h", m_data, PAT_CC); end
  endtask

  task automatic test_short_frame();
    int errs, err_at;
    logic mv;
    send_frame(5, POS5, POS5, errs, err_at, mv);
    tests++; if (errs != 1) begin fails++; $display("FAIL short_errs got=%0d exp=1", errs); end
    tests++; if (err_at != 5) begin fails++; $display("FAIL short_err_at got=%0d exp=5", err_at); end
    tests++; if (mv !== 1'b0) begin fails++; $display("FAIL short_mvalid got=%b exp=0", mv); end
    @(negedge clk);
    tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL short_pulse_width got=%b exp=0", frame_err); end
    send_frame(32, POS5, NEG5, errs, err_at, mv);
    tests++; if (mv !== 1'b1) begin fails++; $display("FAIL short_next_mvalid got=%b exp=1", mv); end
    tests++; if (m_data !== PAT_33) begin fails++; $display("FAIL short_next_data got=%h exp=%h", m_data, PAT_33); end
    handoff();
  endtask

  task automatic test_long_frame();
    int errs, err_at;
    logic mv;
    send_frame(40, NEG5, POS5, errs, err_at, mv);
    tests++; if (errs != 1) begin fails++; $display("FAIL long_errs got=%0d exp=1", errs); end
    tests++; if (err_at != 32) begin fails++; $display("FAIL long_err_at got=%0d exp=32", err_at); end
    tests++; if (mv !== 1'b0) begin fails++; $display("FAIL long_mvalid got=%b exp=0", mv); end
    send_frame(32, NEG5, POS5, errs, err_at, mv);
    tests++; if (mv !== 1'b1 || errs != 0) begin fails++; $display("FAIL long_next got mv=%b errs=%0d exp mv=1 errs=0", mv, errs); end
    tests++; if (m_data !== PAT_CC) begin fails++; $display("FAIL long_next_data got=%h exp=%h", m_data, PAT_CC); end
    handoff();
  endtask

  task automatic test_quantize();
    for (int f = 0; f < 4; f++) begin
      wr_thr(8'(f), 2'd0, 16'hFF9C);
      wr_thr(8'(f), 2'd1, 16'h0000);
      wr_thr(8'(f), 2'd2, 16'h0064);
    end
    send(16'hFF38, 1'b0);
    send(16'hFF9C, 1'b0);
    send(16'h0032, 1'b0);
    send(16'h0064, 1'b0);
    for (int i = 4; i < 32; i++) send(NEG1, (i == 31));
    tests++; if (m_valid !== 1'b1) begin fails++; $display("FAIL quant_mvalid got=%b exp=1", m_valid); end
    tests++; if (m_data[7:0] !== 8'hE4) begin fails++; $display("FAIL quant_codes got=%h exp=e4", m_data[7:0]); end
    tests++; if (m_data !== 64'hE4) begin fails++; $display("FAIL quant_vector got=%h exp=%h", m_data, 64'hE4); end
    handoff();
  endtask

  task automatic test_back_to_back();
    int errs, err_at, c1, c2;
    logic mv;
    m_ready = 1'b1;
    send_frame(32, NEG5, POS5, errs, err_at, mv);
    c1 = cyc;
    tests++; if (m_data !== 64'hCCCC_CCCC_CCCC_CC99) begin fails++; $display("FAIL b2b_data1 got=%h exp=cccccccccccccc99", m_data); end
    send_frame(32, POS5, NEG5, errs, err_at, mv);
    c2 = cyc;
    tests++; if (mv !== 1'b1) begin fails++; $display("FAIL b2b_mvalid2 got=%b exp=1", mv); end
    tests++; if (m_data !== 64'h3333_3333_3333_3366) begin fails++; $display("FAIL b2b_data2 got=%h exp=3333333333333366", m_data); end
    tests++; if (c2 - c1 != 33) begin fails++; $display("FAIL b2b_period got=%0d exp=33", c2 - c1); end
    @(negedge clk);
    m_ready = 1'b0;
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL b2b_release got=%b exp=0", m_valid); end
  endtask

  task automatic test_midframe_thr_write();
    do_reset();
    send(NEG1, 1'b0);
    send(NEG1, 1'b0);
    send(NEG1, 1'b0);
    wr_thr(8'd3, 2'd1, 16'h01F4);
    wr_thr(8'd35, 2'd0, 16'h03E8);
    wr_thr(8'd3, 2'd3, 16'h03E8);
    send(16'h01F3, 1'b0);
    for (int i = 4; i < 32; i++) send(NEG1, (i == 31));
    tests++; if (m_valid !== 1'b1) begin fails++; $display("FAIL midwr_mvalid got=%b exp=1", m_valid); end
    tests++; if (m_data !== 64'h80) begin fails++; $display("FAIL midwr_data got=%h exp=%h", m_data, 64'h80); end
    handoff();
  endtask

  task automatic test_reset_hold();
    int errs, err_at;
    logic mv;
    send(NEG1, 1'b0); send(NEG1, 1'b0); send(NEG1, 1'b0);
    send(16'h01F3, 1'b0);
    for (int i = 4; i < 32; i++) send(NEG1, (i == 31));
    repeat (2) @(negedge clk);
    tests++; if (m_valid !== 1'b1) begin fails++; $display("FAIL rhold_pre got=%b exp=1", m_valid); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL rhold_mvalid got=%b exp=0", m_valid); end
    tests++; if (m_data !== 64'h0) begin fails++; $display("FAIL rhold_mdata got=%h exp=0", m_data); end
    tests++; if (s_ready !== 1'b0) begin fails++; $display("FAIL rhold_sready got=%b exp=0", s_ready); end
    @(negedge clk);
    tests++; if (s_ready !== 1'b1 || frame_err !== 1'b0) begin fails++; $display("FAIL rhold_after got rdy=%b err=%b exp rdy=1 err=0", s_ready, frame_err); end
    // Thresholds are cleared, so 499 now meets all three slots.
    send(NEG1, 1'b0); send(NEG1, 1'b0); send(NEG1, 1'b0);
    send(16'h01F3, 1'b0);
    for (int i = 4; i < 32; i++) send(NEG1, (i == 31));
    tests++; if (m_data !== 64'hC0) begin fails++; $display("FAIL rhold_thr_clr got=%h exp=%h", m_data, 64'hC0); end
    handoff();
    send_frame(32, NEG5, POS5, errs, err_at, mv); handoff();
    send_frame(32, NEG5, POS5, errs, err_at, mv); handoff();
    send_frame(3, POS5, POS5, errs, err_at, mv);
    @(negedge clk);
`ifdef LOGICNET_QUANT_STATS_EN
    tests++; if (stat_frames !== 16'd3) begin fails++; $display("FAIL stat_frames got=%0d exp=3", stat_frames); end
    tests++; if (stat_errs !== 16'd1) begin fails++; $display("FAIL stat_errs got=%0d exp=1", stat_errs); end
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    tests++; if (stat_frames !== 16'd0 || stat_errs !== 16'd0) begin fails++; $display("FAIL stat_clr got=%0d/%0d exp=0/0", stat_frames, stat_errs); end
`endif
    tests++; if (errs != 1 || mv !== 1'b0) begin fails++; $display("FAIL rhold_bad_frame got errs=%0d mv=%b exp errs=1 mv=0", errs, mv); end
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_short_frame();
    test_long_frame();
    test_quantize();
    test_back_to_back();
    test_midframe_thr_write();
    test_reset_hold();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
